gpio_input: RTL

GPIO_INPUT -- requirements
Module: gpio_input

---
 rtl/gpio_pkg.sv | 24 ++
 rtl/gpio_input_fifo.sv | 95 +++++++++
 rtl/gpio_input.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO input capture block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_pkg;

  // Width of a captured word presented to the consumer.
  localparam int DATA_W = 32;
  // Width of the slide-switch bank.
  localparam int SW_W   = 16;

  // Button debounce states.
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_e;

  // Zero-extend a switch snapshot into a data word.
  function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] sw);
    return {{(DATA_W-SW_W){1'b0}}, sw};
  endfunction

endpackage

// File: rtl/gpio_input_fifo.sv
// Capture FIFO: circular buffer of words with sticky overflow flag.
// Latency: a push is visible on rd_vld/rd_dat the cycle after it is written.
// Backpressure: none upstream; a push while full (without a pop) is dropped and flagged.
// Ports: clk, n_rst (sync, active-low); wr_vld/wr_dat push side; rd_en pop request;
//        clr_ovf clears overflow; rd_dat/rd_vld head word; occ occupancy; overflow sticky flag.
module gpio_input_fifo
  import gpio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_vld,
  input  logic [DATA_W-1:0]        wr_dat,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        rd_dat,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d;

  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign rd_vld  = (occ_q != '0);
  assign do_pop  = rd_en && rd_vld;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = wr_vld && (!full || do_pop);
  assign drop    = wr_vld && full && !do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wr_dat;
      // Depth is a power of two, so the pointer wraps by natural overflow.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // A same-cycle overflow wins over the clear.
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: rd_dat is gated by rd_vld.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat   = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign occ      = occ_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/gpio_input.sv
// GPIO input: synchronise switches/button, debounce button, capture switch word into FIFO.
// Latency: DEBOUNCE_CYCLES+3 cycles from first edge sampling btn_in=1 to rd_valid=1.
// Backpressure: consumer pops with rd_en; captures while full are dropped and flag overflow.
// Ports: clk, n_rst (sync, active-low); sw_in[15:0], btn_in async inputs; rd_en pop;
//        clr_ovf clears overflow; rd_data head word; rd_valid non-empty; fifo_occ occupancy;
//        overflow sticky lost-capture flag; irq (only with GPIO_INPUT_IRQ_EN defined).
module gpio_input
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [SW_W-1:0]               sw_in,
  input  logic                          btn_in,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_occ,
  output logic                          overflow
`ifdef GPIO_INPUT_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  // Two-flop synchronisers.
  logic [SW_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;

  deb_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            push;
  logic            cnt_done;

  always_comb begin
    sw_s1_d  = sw_in;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = btn_in;
    btn_s2_d = btn_s1_q;
  end

  // The counter runs while in a wait state; reaching DEBOUNCE_CYCLES completes the wait.
  // This terminal value gives the DEBOUNCE_CYCLES+3 press-to-valid latency once the
  // synchroniser and IDLE-exit cycles are included.
  assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HELD;
          cnt_d   = '0;
          push    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  gpio_input_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_vld   (push),
    .wr_dat   (zext_sw(sw_s2_q)),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_dat   (rd_data),
    .rd_vld   (rd_valid),
    .occ      (fifo_occ),
    .overflow (overflow)
  );

`ifdef GPIO_INPUT_IRQ_EN
  logic irq_q, irq_d;
  logic pop_now;
  logic push_ok;

  assign pop_now = rd_en && rd_valid;
  assign push_ok = push && ((fifo_occ != OCC_W'(FIFO_DEPTH)) || pop_now);

  always_comb begin
    irq_d = irq_q;
    // Popping the last entry clears, unless a new word lands in the same cycle.
    if (pop_now && (fifo_occ == OCC_W'(1))) irq_d = 1'b0;
    if (push_ok)                            irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
